// File: rtl/led_walk_pkg.sv
// Shared types and pattern decoding for the LED walking-light decoder.
// The four legal patterns are one-hot, with led1 as bit 0.
package led_walk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    TRACK  = 2'd2
  } state_t;

  typedef logic [1:0] pos_t;

  localparam logic [3:0] PAT_NONE = 4'b0000;
  localparam logic [3:0] PAT_LED1 = 4'b0001;
  localparam logic [3:0] PAT_LED2 = 4'b0010;
  localparam logic [3:0] PAT_LED3 = 4'b0100;
  localparam logic [3:0] PAT_LED4 = 4'b1000;

  typedef struct packed {
    logic legal;
    pos_t pos;
  } pat_info_t;

  function automatic pat_info_t decode_pat(input logic [3:0] pat);
    pat_info_t info;
    info = '0;
    unique case (pat)
      PAT_LED1: begin info.legal = 1'b1; info.pos = 2'd0; end
      PAT_LED2: begin info.legal = 1'b1; info.pos = 2'd1; end
      PAT_LED3: begin info.legal = 1'b1; info.pos = 2'd2; end
      PAT_LED4: begin info.legal = 1'b1; info.pos = 2'd3; end
      default:  info = '0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/led_sync_stable.sv
// Two-flop synchroniser per LED line followed by a stability filter that
// accepts each new pattern once, after it has been held STABLE_CYC samples.
module led_sync_stable #(
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_led,
  output logic       acc_valid,
  output logic [3:0] acc_pat
);

  localparam int unsigned CW = $clog2(STABLE_CYC + 1);
  localparam logic [CW:0] L_STABLE = (CW + 1)'(STABLE_CYC);
  localparam logic [CW:0] L_ONE    = (CW + 1)'(1);

  logic [3:0]  r_meta;
  logic [3:0]  r_sync;
  logic [3:0]  r_prev;
  logic [3:0]  r_acc;
  logic [CW:0] r_cnt;
  logic [CW:0] w_run;
  logic        w_accept;

  // w_run is the run length including the sample taken at this edge
  always_comb begin
    w_run    = (r_sync == r_prev) ? (r_cnt + 1'b1) : L_ONE;
    w_accept = (w_run >= L_STABLE) && (r_sync != r_acc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
      r_prev <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
    end else begin
      r_meta <= i_led;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_cnt  <= (w_run >= L_STABLE) ? L_STABLE : w_run;
      if (w_accept) begin
        r_acc <= r_sync;
      end
    end
  end

  assign acc_valid = w_accept;
  assign acc_pat   = r_sync;

endmodule

// File: rtl/led_walk_decoder.sv
// Recovers position and rotation direction from the four LED lines and
// flags illegal patterns, two-position jumps and stalls.
module led_walk_decoder
  import led_walk_pkg::*;
#(
  parameter int unsigned STABLE_CYC = 4,
  parameter int unsigned TIMEOUT    = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       led1,
  input  logic       led2,
  input  logic       led3,
  input  logic       led4,
  output logic [1:0] pos,
  output logic       dir_out,
  output logic       dir_valid,
  output logic       step,
  output logic       dir_change,
  output logic       err,
  output logic       stall,
  output logic [7:0] err_cnt
);

  localparam logic [15:0] L_TIMEOUT = 16'(TIMEOUT);

  logic [3:0] w_led;
  logic       w_acc_valid;
  logic [3:0] w_acc_pat;

  state_t     r_state, w_state_nx;
  pos_t       r_pos, w_pos_nx;
  logic       r_dir, w_dir_nx;
  logic       r_dv, w_dv_nx;
  logic       r_step, w_step_nx;
  logic       r_err, w_err_nx;
  logic       r_dchg, w_dchg_nx;
  logic       r_stall, w_stall_nx;
  logic [15:0] r_scnt, w_scnt_nx;
  logic [7:0] r_err_cnt, w_err_cnt_nx;

  pat_info_t  w_info;
  pos_t       w_delta;
  logic       w_dir_new;

  assign w_led = {led4, led3, led2, led1};

  led_sync_stable #(
    .STABLE_CYC(STABLE_CYC)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_led    (w_led),
    .acc_valid(w_acc_valid),
    .acc_pat  (w_acc_pat)
  );

  // 2-bit subtraction gives the position delta modulo 4 directly
  always_comb begin
    w_state_nx = r_state;
    w_pos_nx   = r_pos;
    w_dir_nx   = r_dir;
    w_dv_nx    = r_dv;
    w_step_nx  = 1'b0;
    w_err_nx   = 1'b0;
    w_dchg_nx  = 1'b0;
    w_info     = decode_pat(w_acc_pat);
    w_delta    = w_info.pos - r_pos;
    w_dir_new  = (w_delta == 2'd3);
    if (w_acc_valid) begin
      unique case (r_state)
        IDLE: begin
          if (w_acc_pat != PAT_NONE) begin
            if (w_info.legal) begin
              w_pos_nx   = w_info.pos;
              w_state_nx = LOCKED;
            end else begin
              w_err_nx = 1'b1;
            end
          end
        end
        LOCKED, TRACK: begin
          if (!w_info.legal) begin
            w_err_nx   = 1'b1;
            w_dv_nx    = 1'b0;
            w_state_nx = IDLE;
          end else if (w_delta == 2'd2) begin
            w_err_nx   = 1'b1;
            w_pos_nx   = w_info.pos;
            w_dv_nx    = 1'b0;
            w_state_nx = LOCKED;
          end else if (w_delta != 2'd0) begin
            w_step_nx = 1'b1;
            w_pos_nx  = w_info.pos;
            if (r_state == LOCKED) begin
              w_dir_nx   = w_dir_new;
              w_dv_nx    = 1'b1;
              w_state_nx = TRACK;
            end else if (w_dir_new != r_dir) begin
              w_dir_nx  = w_dir_new;
              w_dchg_nx = 1'b1;
            end
          end
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  // An accepted pattern takes priority over the timeout in the same cycle
  always_comb begin
    w_scnt_nx    = r_scnt;
    w_stall_nx   = r_stall;
    w_err_cnt_nx = r_err_cnt;
    if (w_acc_valid || (r_state == IDLE)) begin
      w_scnt_nx  = '0;
      w_stall_nx = 1'b0;
    end else begin
      if (r_scnt != L_TIMEOUT) begin
        w_scnt_nx = r_scnt + 16'd1;
      end
      w_stall_nx = (w_scnt_nx == L_TIMEOUT);
    end
    if (w_err_nx && (r_err_cnt != '1)) begin
      w_err_cnt_nx = r_err_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pos     <= '0;
      r_dir     <= 1'b0;
      r_dv      <= 1'b0;
      r_step    <= 1'b0;
      r_err     <= 1'b0;
      r_dchg    <= 1'b0;
      r_stall   <= 1'b0;
      r_scnt    <= '0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_pos     <= w_pos_nx;
      r_dir     <= w_dir_nx;
      r_dv      <= w_dv_nx;
      r_step    <= w_step_nx;
      r_err     <= w_err_nx;
      r_dchg    <= w_dchg_nx;
      r_stall   <= w_stall_nx;
      r_scnt    <= w_scnt_nx;
      r_err_cnt <= w_err_cnt_nx;
    end
  end

  assign pos        = r_pos;
  assign dir_out    = r_dir;
  assign dir_valid  = r_dv;
  assign step       = r_step;
  assign dir_change = r_dchg;
  assign err        = r_err;
  assign stall      = r_stall;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_led_walk_decoder.sv
// Bench for led_walk_decoder: directed test-plan steps plus a random phase,
// all cycles compared against an event-level reference model.
module tb_led_walk_decoder;

  localparam int STABLE = 4;
  localparam int TMO    = 100;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] drv   = 4'b0000;

  logic [1:0] pos;
  logic       dir_out, dir_valid, step, dir_change, err, stall;
  logic [7:0] err_cnt;

  int tests = 0;
  int fails = 0;

  led_walk_decoder #(
    .STABLE_CYC(STABLE),
    .TIMEOUT   (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .led1      (drv[0]),
    .led2      (drv[1]),
    .led3      (drv[2]),
    .led4      (drv[3]),
    .pos       (pos),
    .dir_out   (dir_out),
    .dir_valid (dir_valid),
    .step      (step),
    .dir_change(dir_change),
    .err       (err),
    .stall     (stall),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: raw-sample run lengths schedule acceptances two edges
  // later; acceptances are then interpreted with position arithmetic mod 4.
  int         edge_n = 0;
  bit         in_rst = 1'b0;
  logic [3:0] prev_raw = 4'b0000;
  int         run = 0;
  logic [3:0] sched_last = 4'b0000;
  logic [3:0] sched [int];
  bit         m_locked = 1'b0, m_dv = 1'b0, m_dir = 1'b0;
  int         m_pos = 0, m_errs = 0, m_last = 0;
  bit         e_step = 1'b0, e_err = 1'b0, e_dchg = 1'b0, e_stall = 1'b0;
  int         n_step = 0, n_err = 0, n_dchg = 0;

  int         s_step, s_err, s_dchg, e0, t_acc, lat, r, n;
  logic [3:0] p;
  logic [15:0] obs16, exp16;

  function automatic int idx_of(input logic [3:0] v);
    int k;
    k = -1;
    if ($countones(v) == 1) begin
      for (int i = 0; i < 4; i++) if (v[i]) k = i;
    end
    return k;
  endfunction

  function automatic logic [15:0] obs_vec();
    return {pos, dir_out, dir_valid, step, dir_change, err, stall, err_cnt};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_locked = 1'b0; m_dv = 1'b0; m_dir = 1'b0; m_pos = 0; m_errs = 0;
    m_last = edge_n; run = 0; prev_raw = 4'b0000; sched_last = 4'b0000;
    sched.delete();
    e_step = 1'b0; e_err = 1'b0; e_dchg = 1'b0; e_stall = 1'b0;
  endtask

  task automatic model_err();
    e_err = 1'b1;
    if (m_errs < 255) m_errs++;
  endtask

  task automatic model_accept(input logic [3:0] pa);
    int np, d;
    bit nd;
    m_last = edge_n;
    np = idx_of(pa);
    if (!m_locked) begin
      if (pa != 4'b0000) begin
        if (np >= 0) begin
          m_pos = np;
          m_locked = 1'b1;
        end else begin
          model_err();
        end
      end
    end else if (np < 0) begin
      model_err();
      m_dv = 1'b0;
      m_locked = 1'b0;
    end else begin
      d = (np - m_pos + 4) % 4;
      if (d == 2) begin
        model_err();
        m_pos = np;
        m_dv = 1'b0;
      end else if (d != 0) begin
        nd = (d == 3);
        e_step = 1'b1;
        if (m_dv && (nd != m_dir)) e_dchg = 1'b1;
        m_pos = np;
        m_dir = nd;
        m_dv = 1'b1;
      end
    end
  endtask

  task automatic model_edge();
    e_step = 1'b0; e_err = 1'b0; e_dchg = 1'b0;
    if (drv == prev_raw) run++;
    else run = 1;
    prev_raw = drv;
    if ((run == STABLE) && (drv != sched_last)) begin
      sched[edge_n + 2] = drv;
      sched_last = drv;
    end
    if (sched.exists(edge_n)) begin
      model_accept(sched[edge_n]);
      sched.delete(edge_n);
    end
    e_stall = m_locked && ((edge_n - m_last) >= TMO);
  endtask

  task automatic cyc();
    @(posedge clk);
    edge_n++;
    if (!in_rst) model_edge();
    #1;
    obs16 = obs_vec();
    exp16 = {2'(m_pos), m_dir, m_dv, e_step, e_dchg, e_err, e_stall, 8'(m_errs)};
    if (step) n_step++;
    if (err) n_err++;
    if (dir_change) n_dchg++;
    chk($sformatf("outputs@%0d", edge_n), 32'(obs16), 32'(exp16));
  endtask

  task automatic hold(input logic [3:0] pat, input int cycles);
    drv = pat;
    repeat (cycles) cyc();
  endtask

  task automatic wait_to(input int target);
    while (edge_n < target) cyc();
  endtask

  task automatic do_reset();
    drv = 4'b0000;
    rst_n = 1'b0;
    in_rst = 1'b1;
    model_clear();
    #1;
    chk("reset_async_outputs", 32'(obs_vec()), 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    in_rst = 1'b0;
    model_clear();
  endtask

  initial begin
    #1;
    do_reset();
    hold(4'b0000, 10);

    // ascending walk with wrap 3 -> 0
    s_step = n_step;
    hold(4'b0001, 50);
    chk("asc_first_no_step", 32'(n_step - s_step), 32'd0);
    hold(4'b0010, 50);
    hold(4'b0100, 50);
    hold(4'b1000, 50);
    hold(4'b0001, 50);
    chk("asc_steps", 32'(n_step - s_step), 32'd4);
    chk("asc_dir_out", 32'(dir_out), 32'd0);
    chk("asc_dir_valid", 32'(dir_valid), 32'd1);
    chk("asc_wrap_pos", 32'(pos), 32'd0);
    chk("asc_err_cnt", 32'(err_cnt), 32'd0);

    // reversal
    hold(4'b0010, 50);
    s_dchg = n_dchg;
    hold(4'b0001, 50);
    chk("rev_dir_change", 32'(n_dchg - s_dchg), 32'd1);
    chk("rev_dir_out", 32'(dir_out), 32'd1);
    s_step = n_step;
    hold(4'b1000, 50);
    chk("rev_wrap_step", 32'(n_step - s_step), 32'd1);
    chk("rev_no_second_change", 32'(n_dchg - s_dchg), 32'd1);
    chk("rev_pos", 32'(pos), 32'd3);

    // faults
    do_reset();
    s_err = n_err;
    s_step = n_step;
    hold(4'b0011, 50);
    chk("fault_idle_err", 32'(n_err - s_err), 32'd1);
    hold(4'b0001, 50);
    hold(4'b0100, 50);
    chk("fault_jump_err_cnt", 32'(err_cnt), 32'd2);
    chk("fault_jump_pos", 32'(pos), 32'd2);
    chk("fault_jump_dir_valid", 32'(dir_valid), 32'd0);
    chk("fault_no_steps", 32'(n_step - s_step), 32'd0);
    hold(4'b1000, 50);
    chk("fault_locked_step", 32'(n_step - s_step), 32'd1);
    chk("fault_locked_dir_valid", 32'(dir_valid), 32'd1);

    // stall onset, saturation, clear, and tie with an accepted step
    e0 = edge_n;
    drv = 4'b0001;
    t_acc = e0 + 1 + STABLE + 1;
    wait_to(t_acc);
    chk("stall_acc_step", 32'(step), 32'd1);
    wait_to(t_acc + TMO - 1);
    chk("stall_before_timeout", 32'(stall), 32'd0);
    cyc();
    chk("stall_at_timeout", 32'(stall), 32'd1);
    hold(4'b0001, 5);
    chk("stall_held", 32'(stall), 32'd1);
    e0 = edge_n;
    drv = 4'b0010;
    t_acc = e0 + 1 + STABLE + 1;
    wait_to(t_acc);
    chk("stall_clear_step", 32'(step), 32'd1);
    chk("stall_cleared", 32'(stall), 32'd0);
    wait_to(t_acc + TMO - 6);
    drv = 4'b0100;
    wait_to(t_acc + TMO);
    chk("tie_step", 32'(step), 32'd1);
    chk("tie_stall_low", 32'(stall), 32'd0);
    hold(4'b0100, 20);

    // glitch shorter than the filter, then latency of a held change
    s_step = n_step;
    s_err = n_err;
    hold(4'b1000, 3);
    hold(4'b0100, 40);
    chk("glitch_no_event", 32'((n_step - s_step) + (n_err - s_err)), 32'd0);
    chk("glitch_pos", 32'(pos), 32'd2);
    e0 = edge_n;
    drv = 4'b1000;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (step && (lat < 0)) lat = edge_n - (e0 + 1);
    end
    chk("latency_edges", 32'(lat), 32'd5);

    // random phase
    for (int k = 0; k < 80; k++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6) p = 4'b0001 << $urandom_range(0, 3);
      else if (r < 7) p = 4'b0000;
      else p = 4'($urandom_range(0, 15));
      r = int'($urandom_range(0, 9));
      if (r < 2) n = int'($urandom_range(1, 3));
      else if (r < 9) n = int'($urandom_range(4, 30));
      else n = int'($urandom_range(95, 130));
      hold(p, n);
    end

    // reset in the middle of tracking with three errors recorded
    do_reset();
    hold(4'b0011, 30);
    hold(4'b0001, 30);
    hold(4'b0100, 30);
    hold(4'b0101, 30);
    hold(4'b0001, 30);
    hold(4'b0010, 30);
    chk("pre_reset_err_cnt", 32'(err_cnt), 32'd3);
    chk("pre_reset_tracking", 32'(dir_valid), 32'd1);
    do_reset();
    s_err = n_err;
    hold(4'b0000, 20);
    chk("post_reset_idle_zero", 32'(n_err - s_err), 32'd0);

    // error counter saturation
    do_reset();
    for (int k = 0; k < 130; k++) begin
      hold(4'b0011, 5);
      hold(4'b0101, 5);
    end
    hold(4'b0110, 10);
    chk("err_cnt_saturated", 32'(err_cnt), 32'd255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
